apb_fifo_slave: RTL and testbench
=================================

# apb_fifo_slave

APB slave peripheral fronting a small synchronous FIFO: software pushes words by writing the DATA register and pops them by reading it, with status and control registers alongside. It is the design under test that the equivalence bench instantiates twice and drives from shared APB stimulus, so its PRDATA, PREADY and PSLVERR must be fully deterministic every cycle.

## Interface
- DATA_WIDTH, 32: FIFO word and APB data width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PCLK  input  1  APB clock; all state on rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase marker.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  4  byte address; bits [1:0] ignored.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data; 0 whenever no read completes.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response, valid only when PREADY is high in an access phase.

## Operation
- Register map: 0x0 DATA (W push, R pop); 0x4 STATUS (RO: [3:0] count, [4] empty, [5] full, [6] overflow sticky, [7] underflow sticky); 0x8 CTRL (W: bit0 flush, bit1 clear stickies; self-clearing, reads 0); 0xC unmapped.
- Push on a completed DATA write: stores PWDATA at the tail. If full, the word is dropped and overflow is set.
- Pop on a DATA read: returns the head. If empty, returns 0, no pointer move, and underflow is set.
- Flush: count ← 0, pointers ← 0; stored words are not cleared.
- Clear stickies: overflow ← 0, underflow ← 0. When flush and clear are written together, both take effect.
- Error conditions: push when full, pop when empty, any access to 0xC, write to STATUS.
- FSM states:
  - IDLE → RD_WAIT on an access phase (PSEL&PENABLE) that is a DATA read.
  - RD_WAIT → IDLE unconditionally on the next cycle.
- Protocol abort: if PSEL drops while in RD_WAIT, the FSM still returns to IDLE and the pop remains committed.
- Count width is $clog2(DEPTH+1); pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes below 0.
- Reset, mid-transfer or otherwise, forces: IDLE, count 0, pointers 0, stickies 0, read-data register 0.

## Timing
- Reset values: PRDATA 0, PREADY 1, PSLVERR 0.
- Non-DATA-read access: zero wait states.
  - PREADY is high in the first access cycle.
  - PRDATA is a combinational register mux, gated by PSEL&PENABLE&!PWRITE.
  - Write side effects take place at the end of that cycle.
- DATA read: exactly one wait state.
  - Access cycle 1 (IDLE): PREADY 0. The head is latched into the read-data register and the pointer/count update at the clock edge.
  - Access cycle 2 (RD_WAIT): PREADY 1, PRDATA = latched word.
- PREADY = !(IDLE & PSEL & PENABLE & !PWRITE & PADDR[3:2]==0). It is high during setup and idle.
- STATUS read reflects the state before the current access; pops are committed one cycle earlier.
- Back-to-back DATA reads with no idle cycle pop consecutive entries correctly.
- No simultaneous push/pop is possible (single APB port). Flush and push cannot coincide.

## Configuration
- APB_FIFO_SLAVE_PSLVERR_EN defined: PSLVERR = 1 in the completing cycle of any error condition. The side effects described in Operation still apply.
- Not defined: PSLVERR is tied 0. Errors are visible only through the STATUS stickies, and unmapped reads return 0.

## Structure
- Package apb_fifo_slave_pkg:
  - address constants ADDR_DATA/STATUS/CTRL;
  - CTRL bit indices;
  - packed status_t struct;
  - FSM state enum.
- Sub-module fifo_core: synchronous FIFO with push, pop, flush, head, count, full and empty outputs; no APB knowledge. The top level holds the FSM, decode, stickies and PRDATA mux.

## Test plan
- Reset, then read STATUS → PRDATA 0x10 (empty), PREADY high in the first access cycle, PSLVERR 0.
- Write 0xA, 0xB, 0xC, 0xD to DATA; read STATUS → 0x24. A fifth write of 0xE → PSLVERR 1 (with macro) and STATUS 0x64.
- Four DATA reads, back-to-back → each has PREADY low for exactly 1 cycle, then PRDATA 0xA, 0xB, 0xC, 0xD. A fifth read → PRDATA 0, underflow set.
- Push 0x1, 0x2; write CTRL = 0x3 → STATUS 0x10. A subsequent DATA read → PRDATA 0.
- Assert PRESETn low during cycle 1 of a DATA read with 2 entries stored → outputs return to reset values immediately, STATUS 0x10 after release.
- Read 0xC; write STATUS → PSLVERR 1 with the macro and 0 without; PRDATA 0; FIFO unchanged.

Source files
------------

// File: rtl/apb_fifo_slave_pkg.sv
// Shared definitions for the APB FIFO slave: register map, CTRL bits,
// STATUS layout and FSM states.
package apb_fifo_slave_pkg;

  localparam logic [3:0] ADDR_DATA     = 4'h0;
  localparam logic [3:0] ADDR_STATUS   = 4'h4;
  localparam logic [3:0] ADDR_CTRL     = 4'h8;
  localparam logic [3:0] ADDR_UNMAPPED = 4'hC;

  localparam int unsigned CTRL_FLUSH_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

  typedef struct packed {
    logic       underflow;
    logic       overflow;
    logic       full;
    logic       empty;
    logic [3:0] count;
  } status_t;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

endpackage

// File: rtl/apb_fifo_slave_fifo_core.sv
// Synchronous FIFO with push/pop/flush; pushes when full and pops when
// empty are ignored. Flush resets pointers and count but keeps storage.
module fifo_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH-1:0]        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o && !flush_i;
    do_pop   = pop_i && !empty_o && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      if (do_push && !do_pop) count_d = CNT_W'(count_q + 1'b1);
      if (do_pop && !do_push) count_d = CNT_W'(count_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave fronting a FIFO: DATA push/pop, STATUS, CTRL flush/clear.
// Optional PSLVERR reporting under APB_FIFO_SLAVE_PSLVERR_EN.
module apb_fifo_slave
  import apb_fifo_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [3:0]            PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  access;
  logic [3:0]            word;
  logic                  sel_data, sel_status, sel_ctrl;
  logic                  push, pop, flush;
  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  status_t               status;
  logic                  pready_c;
  logic [DATA_WIDTH-1:0] prdata_c;
  logic                  unused_addr;

  assign unused_addr = ^PADDR[1:0];

  fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (PWDATA),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    status.underflow = udf_q;
    status.overflow  = ovf_q;
    status.full      = full;
    status.empty     = empty;
    status.count     = 4'(count);
  end

  // Decode, FSM next state, FIFO controls and read mux.
  always_comb begin
    access     = PRESETn && PSEL && PENABLE;
    word       = {PADDR[3:2], 2'b00};
    sel_data   = (word == ADDR_DATA);
    sel_status = (word == ADDR_STATUS);
    sel_ctrl   = (word == ADDR_CTRL);

    state_d  = state_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    pready_c = 1'b1;
    prdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (access && !PWRITE) begin
          if (sel_data) begin
            pready_c = 1'b0;
            pop      = !empty;
            rdata_d  = empty ? '0 : head;
            udf_d    = udf_q | empty;
            state_d  = ST_RD_WAIT;
          end else if (sel_status) begin
            prdata_c = DATA_WIDTH'(status);
          end
        end
      end
      ST_RD_WAIT: begin
        // Pop was committed in the previous cycle even if PSEL has dropped.
        state_d = ST_IDLE;
        if (access && !PWRITE) prdata_c = rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (access && PWRITE) begin
      if (sel_data) begin
        push  = !full;
        ovf_d = ovf_q | full;
      end
      if (sel_ctrl) begin
        flush = PWDATA[CTRL_FLUSH_BIT];
        if (PWDATA[CTRL_CLR_BIT]) begin
          ovf_d = 1'b0;
          udf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign PRDATA = prdata_c;
  assign PREADY = pready_c;

`ifdef APB_FIFO_SLAVE_PSLVERR_EN
  logic rd_err_q;
  logic err_now_c;

  // An empty-pop error is reported in the wait-state completion cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rd_err_q <= 1'b0;
    else          rd_err_q <= (state_q == ST_IDLE) && access && !PWRITE && sel_data && empty;
  end

  assign err_now_c = (word == ADDR_UNMAPPED) || (PWRITE && sel_status) || (PWRITE && sel_data && full);
  assign PSLVERR   = access && pready_c && (err_now_c || ((state_q == ST_RD_WAIT) && rd_err_q));
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed, table-driven bench for apb_fifo_slave plus hand-written
// sequences for reset-during-read and protocol abort.
module tb_apb_fifo_slave;

`ifdef APB_FIFO_SLAVE_PSLVERR_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_fifo_slave #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_waits;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic void add(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp, input int waits, input logic err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd;
    v.exp_rdata = exp; v.exp_waits = waits; v.exp_err = err;
    vq.push_back(v);
  endfunction

  // One APB transfer; samples at the completing cycle, 1 time unit after negedge.
  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    waits = 0;
    while (!PREADY && waits < 8) begin
      waits++;
      @(negedge PCLK);
      #1;
    end
    rd  = PRDATA;
    err = PSLVERR;
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic run_xfer(input string name, input logic wr, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp, input int ew, input logic ee);
    logic [31:0] rd;
    logic        err;
    int          waits;
    xfer(wr, addr, wd, rd, err, waits);
    check({name, " rdata"}, rd, exp);
    check({name, " waits"}, 32'(waits), 32'(ew));
    check({name, " pslverr"}, 32'(err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main register-map vectors: {wr, addr, wdata, exp_rdata, exp_waits, exp_err}
    add(0, 4'h4, 0,     32'h10, 0, 0);
    add(1, 4'h0, 32'hA, 0,      0, 0);
    add(1, 4'h0, 32'hB, 0,      0, 0);
    add(1, 4'h0, 32'hC, 0,      0, 0);
    add(1, 4'h0, 32'hD, 0,      0, 0);
    add(0, 4'h4, 0,     32'h24, 0, 0);
    add(1, 4'h0, 32'hE, 0,      0, E);
    add(0, 4'h4, 0,     32'h64, 0, 0);
    add(0, 4'h0, 0,     32'hA,  1, 0);
    add(0, 4'h0, 0,     32'hB,  1, 0);
    add(0, 4'h0, 0,     32'hC,  1, 0);
    add(0, 4'h0, 0,     32'hD,  1, 0);
    add(0, 4'h0, 0,     32'h0,  1, E);
    add(0, 4'h4, 0,     32'hD0, 0, 0);
    add(1, 4'h8, 32'h2, 0,      0, 0);
    add(0, 4'h4, 0,     32'h10, 0, 0);
    add(1, 4'h0, 32'h1, 0,      0, 0);
    add(1, 4'h0, 32'h2, 0,      0, 0);
    add(1, 4'h8, 32'h3, 0,      0, 0);
    add(0, 4'h4, 0,     32'h10, 0, 0);
    add(0, 4'h0, 0,     32'h0,  1, E);
    add(0, 4'h4, 0,     32'h90, 0, 0);
    add(1, 4'h8, 32'h2, 0,      0, 0);
    add(1, 4'h0, 32'h7, 0,      0, 0);
    add(0, 4'hC, 0,     32'h0,  0, E);
    add(1, 4'h4, 32'hFF, 0,     0, E);
    add(1, 4'hC, 32'h5, 0,      0, E);
    add(0, 4'h5, 0,     32'h01, 0, 0);
    add(0, 4'h0, 0,     32'h7,  1, 0);
    add(0, 4'h8, 0,     32'h0,  0, 0);

    // Reset state
    PRESETn = 1'b0;
    #1;
    check("reset pready", 32'(PREADY), 32'h1);
    check("reset prdata", PRDATA, 32'h0);
    check("reset pslverr", 32'(PSLVERR), 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    foreach (vq[i]) begin
      run_xfer($sformatf("v%0d", i), vq[i].wr, vq[i].addr, vq[i].wdata,
               vq[i].exp_rdata, vq[i].exp_waits, vq[i].exp_err);
    end
    go_idle();
    #1;
    check("idle pready", 32'(PREADY), 32'h1);
    check("idle prdata", PRDATA, 32'h0);

    // Protocol abort: PSEL drops in the wait state, pop stays committed.
    run_xfer("ab push0", 1, 4'h0, 32'h33, 0, 0, 0);
    run_xfer("ab push1", 1, 4'h0, 32'h44, 0, 0, 0);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    #1;
    check("ab setup pready", 32'(PREADY), 32'h1);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    check("ab access pready", 32'(PREADY), 32'h0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check("ab dropped prdata", PRDATA, 32'h0);
    check("ab dropped pready", 32'(PREADY), 32'h1);
    run_xfer("ab status", 0, 4'h4, 0, 32'h01, 0, 0);
    run_xfer("ab pop", 0, 4'h0, 0, 32'h44, 1, 0);

    // Reset asserted during the first cycle of a DATA read.
    run_xfer("rs push0", 1, 4'h0, 32'h11, 0, 0, 0);
    run_xfer("rs push1", 1, 4'h0, 32'h22, 0, 0, 0);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    check("rs access pready", 32'(PREADY), 32'h0);
    PRESETn = 1'b0;
    #1;
    check("rs pready", 32'(PREADY), 32'h1);
    check("rs prdata", PRDATA, 32'h0);
    check("rs pslverr", 32'(PSLVERR), 32'h0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    run_xfer("rs status", 0, 4'h4, 0, 32'h10, 0, 0);
    run_xfer("rs pop", 0, 4'h0, 0, 32'h0, 1, E);
    run_xfer("rs status2", 0, 4'h4, 0, 32'h90, 0, 0);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
